// File: rtl/counter_seg_pkg.sv
// Shared constants, types and the glyph table for the multi-digit counter and its
// time-multiplexed 7-segment display driver.
package counter_seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_BCD = 1'b1
    } count_mode_e;

    // Active-low segment patterns in {g,f,e,d,c,b,a} order, indexed by digit value
    localparam logic [6:0] GLYPHS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/counter_seg_mux_seg7_decode.sv
// Combinational 4-bit digit to active-low 7-segment glyph lookup.
module seg7_decode
    import counter_seg_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    assign seg = GLYPHS[digit];

endmodule

// File: rtl/counter_seg_mux.sv
// Multi-digit hex/BCD up/down counter with parallel load, wrap carry and a scanned
// common-anode 7-segment display. Optional macro COUNTER_BLANK_EN enables leading-zero blanking.
module counter_seg_mux
    import counter_seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up,
    input  logic                      mode,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      carry,
    output logic [6:0]                seg,
    output logic [DIGITS-1:0]         an
);

    localparam int CW    = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    count_mode_e      cur_mode;
    digit_t           d_max;
    logic [CW-1:0]    count_next;
    logic             carry_next;
    logic             chain;
    digit_t           d;
    digit_t           d_step;
    logic             at_bound;

    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] scan_idx;
    logic             presc_done;
    digit_t           cur_digit;
    logic             cur_blank;
    logic [6:0]       glyph;

    assign cur_mode   = count_mode_e'(mode);
    assign d_max      = (cur_mode == MODE_BCD) ? digit_t'(9) : digit_t'(15);
    assign presc_done = (presc == PRE_W'(SCAN_DIV - 1));

    // Ripple the step through the digits: a digit moves only while every lower digit
    // sits on its boundary, and the chain surviving past the top digit is the wrap.
    always_comb begin
        count_next = count;
        carry_next = 1'b0;
        chain      = 1'b1;
        d          = '0;
        d_step     = '0;
        at_bound   = 1'b0;
        if (load) begin
            for (int k = 0; k < DIGITS; k++) begin
                d = load_val[k*DIGIT_W +: DIGIT_W];
                if (cur_mode == MODE_BCD && d > digit_t'(9)) begin
                    d = digit_t'(9);
                end
                count_next[k*DIGIT_W +: DIGIT_W] = d;
            end
        end else if (en) begin
            for (int k = 0; k < DIGITS; k++) begin
                d = count[k*DIGIT_W +: DIGIT_W];
                if (up) begin
                    at_bound = (d >= d_max);
                    d_step   = at_bound ? digit_t'(0) : d + 1'b1;
                end else begin
                    at_bound = (d == '0);
                    d_step   = at_bound ? d_max : ((d > d_max) ? d_max : d - 1'b1);
                end
                if (chain) begin
                    count_next[k*DIGIT_W +: DIGIT_W] = d_step;
                end
                chain = chain & at_bound;
            end
            carry_next = chain;
        end
    end

    // Select the digit under the scan index; walk from the top so blanking knows
    // whether everything above and including this digit is zero.
    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
`ifdef COUNTER_BLANK_EN
        begin : blank_scan
            logic upper_zero;
            upper_zero = 1'b1;
            for (int k = DIGITS - 1; k >= 0; k--) begin
                upper_zero = upper_zero & (count[k*DIGIT_W +: DIGIT_W] == '0);
                if (scan_idx == IDX_W'(k)) begin
                    cur_digit = count[k*DIGIT_W +: DIGIT_W];
                    cur_blank = upper_zero && (k != 0);
                end
            end
        end
`else
        for (int k = 0; k < DIGITS; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                cur_digit = count[k*DIGIT_W +: DIGIT_W];
            end
        end
`endif
    end

    seg7_decode u_decode (
        .digit (cur_digit),
        .seg   (glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            carry    <= 1'b0;
            presc    <= '0;
            scan_idx <= '0;
            an       <= ~DIGITS'(1);
            seg      <= GLYPHS[0];
        end else begin
            count <= count_next;
            carry <= carry_next;
            presc <= presc_done ? '0 : presc + 1'b1;
            if (presc_done) begin
                scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end
            an  <= ~(DIGITS'(1) << scan_idx);
            seg <= cur_blank ? SEG_BLANK : glyph;
        end
    end

endmodule

// File: tb/tb_counter_seg_mux.sv
// Directed self-checking bench for counter_seg_mux (DIGITS=4, SCAN_DIV=4); expectations
// for the blanked digits follow COUNTER_BLANK_EN.
module tb_counter_seg_mux;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

`ifdef COUNTER_BLANK_EN
    localparam logic [6:0] UPPER_ZERO = 7'b1111111;
`else
    localparam logic [6:0] UPPER_ZERO = 7'b1000000;
`endif

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        up;
    logic        mode;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        carry;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    counter_seg_mux #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Load a value over one posedge; returns on the negedge after the load edge.
    task automatic do_load(input logic [15:0] val);
        @(negedge clk);
        load     = 1'b1;
        load_val = val;
        en       = 1'b0;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic pulse_en;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Wait (bounded) for the negedge at which digit 0 has just been enabled.
    task automatic align_scan(output bit ok);
        logic [3:0] prev;
        ok   = 1'b0;
        prev = an;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev != 4'b1110) ok = 1'b1;
            prev = an;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_count: got %h expected 0000", count); end
        checks++;
        if (carry !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry: got %b expected 0", carry); end
        checks++;
        if (an !== 4'b1110) begin errors++; $display("[TB] FAIL reset_an: got %b expected 1110", an); end
        checks++;
        if (seg !== 7'b1000000) begin errors++; $display("[TB] FAIL reset_seg: got %b expected 1000000", seg); end
        reset = 1'b0;

        mode = 1'b0;
        up   = 1'b1;
        do_load(16'h03A7);
        checks++;
        if (count !== 16'h03A7) begin errors++; $display("[TB] FAIL load_03a7: got %h expected 03a7", count); end
        en = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (count !== 16'h0000) begin errors++; $display("[TB] FAIL async_reset_count: got %h expected 0000", count); end
        checks++;
        if (carry !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_carry: got %b expected 0", carry); end
        checks++;
        if (an !== 4'b1110) begin errors++; $display("[TB] FAIL async_reset_an: got %b expected 1110", an); end
        checks++;
        if (seg !== 7'b1000000) begin errors++; $display("[TB] FAIL async_reset_seg: got %b expected 1000000", seg); end
        #1 reset = 1'b0;
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (count !== 16'h0001) begin errors++; $display("[TB] FAIL resume_after_reset: got %h expected 0001", count); end
    endtask

    task automatic test_hex_wrap;
        logic [15:0] exp_count [3];
        logic        exp_carry [3];
        exp_count = '{16'hFFFF, 16'h0000, 16'h0001};
        exp_carry = '{1'b0, 1'b1, 1'b0};
        mode = 1'b0;
        up   = 1'b1;
        do_load(16'hFFFE);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (count !== exp_count[i]) begin errors++; $display("[TB] FAIL hex_up_count[%0d]: got %h expected %h", i, count, exp_count[i]); end
            checks++;
            if (carry !== exp_carry[i]) begin errors++; $display("[TB] FAIL hex_up_carry[%0d]: got %b expected %b", i, carry, exp_carry[i]); end
        end
        en = 1'b0;

        up = 1'b0;
        do_load(16'h0000);
        pulse_en();
        checks++;
        if (count !== 16'hFFFF) begin errors++; $display("[TB] FAIL hex_down_wrap: got %h expected ffff", count); end
        checks++;
        if (carry !== 1'b1) begin errors++; $display("[TB] FAIL hex_down_carry: got %b expected 1", carry); end
        @(negedge clk);
        checks++;
        if (carry !== 1'b0) begin errors++; $display("[TB] FAIL hex_down_carry_clear: got %b expected 0", carry); end
    endtask

    task automatic test_bcd;
        mode = 1'b1;
        up   = 1'b0;
        do_load(16'h0000);
        pulse_en();
        checks++;
        if (count !== 16'h9999) begin errors++; $display("[TB] FAIL bcd_down_wrap: got %h expected 9999", count); end
        checks++;
        if (carry !== 1'b1) begin errors++; $display("[TB] FAIL bcd_down_carry: got %b expected 1", carry); end
        @(negedge clk);
        checks++;
        if (carry !== 1'b0) begin errors++; $display("[TB] FAIL bcd_down_carry_clear: got %b expected 0", carry); end

        do_load(16'h12AF);
        checks++;
        if (count !== 16'h1299) begin errors++; $display("[TB] FAIL bcd_load_saturate: got %h expected 1299", count); end

        up = 1'b1;
        do_load(16'h0199);
        pulse_en();
        checks++;
        if (count !== 16'h0200) begin errors++; $display("[TB] FAIL bcd_up_ripple: got %h expected 0200", count); end
        checks++;
        if (carry !== 1'b0) begin errors++; $display("[TB] FAIL bcd_up_ripple_carry: got %b expected 0", carry); end

        do_load(16'h9999);
        pulse_en();
        checks++;
        if (count !== 16'h0000) begin errors++; $display("[TB] FAIL bcd_up_wrap: got %h expected 0000", count); end
        checks++;
        if (carry !== 1'b1) begin errors++; $display("[TB] FAIL bcd_up_carry: got %b expected 1", carry); end
    endtask

    task automatic test_mode_switch;
        mode = 1'b0;
        do_load(16'h00AF);
        mode = 1'b1;
        up   = 1'b1;
        pulse_en();
        checks++;
        if (count !== 16'h0100) begin errors++; $display("[TB] FAIL switch_bcd_up: got %h expected 0100", count); end

        mode = 1'b0;
        do_load(16'h00A0);
        mode = 1'b1;
        up   = 1'b0;
        pulse_en();
        checks++;
        if (count !== 16'h0099) begin errors++; $display("[TB] FAIL switch_bcd_down: got %h expected 0099", count); end

        mode = 1'b0;
        do_load(16'hFFFF);
        mode = 1'b1;
        up   = 1'b1;
        pulse_en();
        checks++;
        if (count !== 16'h0000) begin errors++; $display("[TB] FAIL switch_bcd_wrap: got %h expected 0000", count); end
        checks++;
        if (carry !== 1'b1) begin errors++; $display("[TB] FAIL switch_bcd_wrap_carry: got %b expected 1", carry); end
    endtask

    task automatic test_load_priority;
        mode = 1'b0;
        up   = 1'b1;
        do_load(16'hFFFF);
        load     = 1'b1;
        en       = 1'b1;
        load_val = 16'h0042;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (count !== 16'h0042) begin errors++; $display("[TB] FAIL load_over_en: got %h expected 0042", count); end
        checks++;
        if (carry !== 1'b0) begin errors++; $display("[TB] FAIL load_over_en_carry: got %b expected 0", carry); end
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (count !== 16'h0043) begin errors++; $display("[TB] FAIL count_after_load: got %h expected 0043", count); end
    endtask

    task automatic test_scan;
        bit          ok;
        logic [15:0] val;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        val = 16'h1234;
        mode = 1'b0;
        do_load(val);
        align_scan(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL scan_align: got an=%b expected 1110 within 40 cycles", an);
        end else begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < SCAN_DIV; c++) begin
                    exp_an  = ~(4'b0001 << d);
                    exp_seg = GLYPH[val[d*4 +: 4]];
                    checks++;
                    if (an !== exp_an) begin errors++; $display("[TB] FAIL scan_an d%0d c%0d: got %b expected %b", d, c, an, exp_an); end
                    checks++;
                    if (seg !== exp_seg) begin errors++; $display("[TB] FAIL scan_seg d%0d c%0d: got %b expected %b", d, c, seg, exp_seg); end
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_blanking;
        bit          ok;
        logic [15:0] vals [2];
        logic [27:0] exp_tab [2];
        vals    = '{16'h0007, 16'h0507};
        exp_tab = '{{UPPER_ZERO, UPPER_ZERO, UPPER_ZERO, 7'b1111000},
                    {UPPER_ZERO, 7'b0010010, 7'b1000000, 7'b1111000}};
        for (int v = 0; v < 2; v++) begin
            do_load(vals[v]);
            align_scan(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL blank_align %h: got an=%b expected 1110 within 40 cycles", vals[v], an);
            end else begin
                for (int d = 0; d < 4; d++) begin
                    checks++;
                    if (seg !== exp_tab[v][d*7 +: 7]) begin
                        errors++;
                        $display("[TB] FAIL blank_seg %h d%0d: got %b expected %b", vals[v], d, seg, exp_tab[v][d*7 +: 7]);
                    end
                    repeat (SCAN_DIV) @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        up       = 1'b1;
        mode     = 1'b0;
        load     = 1'b0;
        load_val = '0;
        test_reset();
        test_hex_wrap();
        test_bcd();
        test_mode_switch();
        test_load_priority();
        test_scan();
        test_blanking();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
